// File: rtl/lsu_memacc_pkg.sv
// Shared types and constants for the MEMACC load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  // True when funct3 names a real RV32I load or store
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_memacc_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
interface lsu_memacc_if #(
  parameter int unsigned ADDR_W = 32
) ();

  // core side
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;

  // memory bus side
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_rsp_valid;
  logic [31:0]       bus_rdata;

  // LSU view
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  // Core + memory view
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );

endinterface

// File: rtl/lsu_memacc_align.sv
// Byte-lane steering, write strobes, load extension and legality checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb_c,
  output logic [31:0] o_wdata_c,
  output logic [31:0] o_rdata_c,
  output logic        o_misalign_c,
  output logic        o_illegal_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Legality: funct3 class first, then natural alignment by access size
  always_comb begin
    o_illegal_c  = !f3_legal(i_is_store, i_funct3);
    o_misalign_c = 1'b0;
    case (i_funct3[1:0])
      2'b01:   o_misalign_c = i_addr_lo[0];
      2'b10:   o_misalign_c = (i_addr_lo != 2'b00);
      default: o_misalign_c = 1'b0;
    endcase
  end

  // Store steering: replicate data across lanes, strobe only the target bytes
  always_comb begin
    o_wstrb_c = 4'b0000;
    o_wdata_c = 32'h0;
    if (i_is_store) begin
      case (i_funct3)
        F3_SB: begin
          o_wstrb_c = 4'(4'b0001 << i_addr_lo);
          o_wdata_c = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_wstrb_c = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata_c = {2{i_wdata[15:0]}};
        end
        F3_SW: begin
          o_wstrb_c = 4'b1111;
          o_wdata_c = i_wdata;
        end
        default: begin
          o_wstrb_c = 4'b0000;
          o_wdata_c = 32'h0;
        end
      endcase
    end
  end

  // Load extraction: pick the addressed byte/half and extend
  always_comb begin
    o_rdata_c = 32'h0;
    case (i_funct3)
      F3_LB:   o_rdata_c = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_rdata_c = {24'h0, w_byte};
      F3_LH:   o_rdata_c = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_rdata_c = {16'h0, w_half};
      F3_LW:   o_rdata_c = i_rdata;
      default: o_rdata_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_memacc.sv
// MEMACC stage: one memory op at a time over a valid/ready word bus,
// with legality checks, lane steering and a response timeout.
module lsu_memacc
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic           clk,
  input  logic           rst,
  lsu_memacc_if.slave    io
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        r_state;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  lsu_err_e          r_resp_err;
  logic              r_bus_req_valid;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wstrb;

  logic              w_idle;
  logic              w_is_store;
  logic [2:0]        w_funct3;
  logic [1:0]        w_addr_lo;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_misalign;
  logic              w_illegal;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // In IDLE the aligner judges the incoming request; afterwards the captured op
  assign w_idle     = (r_state == IDLE);
  assign w_is_store = w_idle ? io.req_is_store   : r_is_store;
  assign w_funct3   = w_idle ? io.req_funct3     : r_funct3;
  assign w_addr_lo  = w_idle ? io.req_addr[1:0]  : r_addr_lo;
  assign w_cnt_nxt  = r_cnt + 1'b1;

  lsu_align u_align (
    .i_is_store   (w_is_store),
    .i_funct3     (w_funct3),
    .i_addr_lo    (w_addr_lo),
    .i_wdata      (io.req_wdata),
    .i_rdata      (io.bus_rdata),
    .o_wstrb_c    (w_wstrb),
    .o_wdata_c    (w_wdata),
    .o_rdata_c    (w_rdata),
    .o_misalign_c (w_misalign),
    .o_illegal_c  (w_illegal)
  );

  assign io.req_ready     = r_req_ready;
  assign io.resp_valid    = r_resp_valid;
  assign io.resp_rdata    = r_resp_rdata;
  assign io.resp_err      = r_resp_err;
  assign io.bus_req_valid = r_bus_req_valid;
  assign io.bus_we        = r_bus_we;
  assign io.bus_addr      = r_bus_addr;
  assign io.bus_wdata     = r_bus_wdata;
  assign io.bus_wstrb     = r_bus_wstrb;

  // Operation FSM with registered outputs and WAIT-state timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_is_store      <= 1'b0;
      r_funct3        <= 3'b000;
      r_addr_lo       <= 2'b00;
      r_cnt           <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= 32'h0;
      r_resp_err      <= ERR_NONE;
      r_bus_req_valid <= 1'b0;
      r_bus_we        <= 1'b0;
      r_bus_addr      <= '0;
      r_bus_wdata     <= 32'h0;
      r_bus_wstrb     <= 4'b0000;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io.req_valid) begin
            r_is_store  <= io.req_is_store;
            r_funct3    <= io.req_funct3;
            r_addr_lo   <= io.req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_illegal || w_misalign) begin
              // Error ops never touch the bus; illegal funct3 outranks misalign
              r_resp_err   <= w_illegal ? ERR_FUNCT3 : ERR_MISALIGN;
              r_resp_rdata <= 32'h0;
              r_resp_valid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_bus_req_valid <= 1'b1;
              r_bus_we        <= io.req_is_store;
              r_bus_addr      <= {io.req_addr[ADDR_W-1:2], 2'b00};
              r_bus_wdata     <= w_wdata;
              r_bus_wstrb     <= w_wstrb;
              r_state         <= REQ;
            end
          end
        end
        REQ: begin
          if (io.bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (io.bus_rsp_valid) begin
            r_resp_rdata <= r_is_store ? 32'h0 : w_rdata;
            r_resp_err   <= ERR_NONE;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
              r_resp_rdata <= 32'h0;
              r_resp_err   <= ERR_TIMEOUT;
              r_resp_valid <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_memacc.sv
// Directed self-checking bench for lsu_memacc (timeout shortened to 4 cycles).
module tb_lsu_memacc;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  lsu_memacc_if #(.ADDR_W(32)) bif ();

  lsu_memacc #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    bif.req_valid    = 1'b1;
    bif.req_is_store = st;
    bif.req_funct3   = f3;
    bif.req_addr     = addr;
    bif.req_wdata    = wd;
  endtask

  // Legal op: bus request checks, optional ready stall, one-cycle response
  task automatic bus_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall,
                        input logic [31:0] rsp, input logic [31:0] exp_addr,
                        input logic [31:0] exp_strb, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    chk({tag, ".ready_in"}, 32'(bif.req_ready), 32'd1);
    drive_req(st, f3, addr, wd);
    tick();                                   // accept edge N
    bif.req_valid = 1'b0;
    chk({tag, ".busv"}, 32'(bif.bus_req_valid), 32'd1);
    chk({tag, ".busy"}, 32'(bif.req_ready), 32'd0);
    chk({tag, ".addr"}, bif.bus_addr, exp_addr);
    chk({tag, ".we"}, 32'(bif.bus_we), 32'(st));
    chk({tag, ".strb"}, 32'(bif.bus_wstrb), exp_strb);
    if (st) chk({tag, ".wdata"}, bif.bus_wdata, exp_wd);
    bif.bus_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".stall_v"}, 32'(bif.bus_req_valid), 32'd1);
      chk({tag, ".stall_a"}, bif.bus_addr, exp_addr);
    end
    bif.bus_req_ready = 1'b1;
    tick();                                   // handshake edge
    bif.bus_req_ready = 1'b0;
    chk({tag, ".busv_off"}, 32'(bif.bus_req_valid), 32'd0);
    chk({tag, ".early"}, 32'(bif.resp_valid), 32'd0);
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata     = rsp;
    tick();                                   // response edge
    bif.bus_rsp_valid = 1'b0;
    chk({tag, ".rv"}, 32'(bif.resp_valid), 32'd1);
    chk({tag, ".rdata"}, bif.resp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(bif.resp_err), 32'd0);
    tick();
    chk({tag, ".pulse"}, 32'(bif.resp_valid), 32'd0);
    chk({tag, ".ready_out"}, 32'(bif.req_ready), 32'd1);
    chk({tag, ".hold"}, bif.resp_rdata, exp_rd);
  endtask

  // Rejected op: response one cycle after acceptance, no bus request
  task automatic err_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp_err);
    drive_req(st, f3, addr, 32'hCAFEF00D);
    tick();
    bif.req_valid = 1'b0;
    chk({tag, ".rv"}, 32'(bif.resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(bif.resp_err), exp_err);
    chk({tag, ".rdata"}, bif.resp_rdata, 32'h0);
    chk({tag, ".nobus"}, 32'(bif.bus_req_valid), 32'd0);
    tick();
    chk({tag, ".pulse"}, 32'(bif.resp_valid), 32'd0);
    chk({tag, ".ready"}, 32'(bif.req_ready), 32'd1);
    chk({tag, ".nobus2"}, 32'(bif.bus_req_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bif.req_valid     = 1'b0;
    bif.req_is_store  = 1'b0;
    bif.req_funct3    = 3'b000;
    bif.req_addr      = 32'h0;
    bif.req_wdata     = 32'h0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rdata     = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst.ready", 32'(bif.req_ready), 32'd1);
    chk("rst.rv", 32'(bif.resp_valid), 32'd0);
    chk("rst.busv", 32'(bif.bus_req_valid), 32'd0);
    chk("rst.strb", 32'(bif.bus_wstrb), 32'd0);
    rst = 1'b0;
    tick();

    // Stores
    bus_op("sb", 1'b1, F3_SB, 32'h66, 32'h123456AB, 0, 32'h55555555,
           32'h64, 32'b0100, 32'hABABABAB, 32'h0);
    bus_op("sh", 1'b1, F3_SH, 32'h66, 32'h0000BEEF, 0, 32'h0,
           32'h64, 32'b1100, 32'hBEEFBEEF, 32'h0);
    bus_op("sw", 1'b1, F3_SW, 32'h70, 32'h89ABCDEF, 0, 32'h0,
           32'h70, 32'b1111, 32'h89ABCDEF, 32'h0);

    // Loads with sign/zero extension
    bus_op("lb", 1'b0, F3_LB, 32'h66, 32'h0, 0, 32'h80FF1234,
           32'h64, 32'b0000, 32'h0, 32'hFFFFFFFF);
    bus_op("lbu", 1'b0, F3_LBU, 32'h66, 32'h0, 0, 32'h80FF1234,
           32'h64, 32'b0000, 32'h0, 32'h000000FF);
    bus_op("lh", 1'b0, F3_LH, 32'h66, 32'h0, 0, 32'h80FF1234,
           32'h64, 32'b0000, 32'h0, 32'hFFFF80FF);
    bus_op("lhu", 1'b0, F3_LHU, 32'h66, 32'h0, 0, 32'h80FF1234,
           32'h64, 32'b0000, 32'h0, 32'h000080FF);
    bus_op("lb0", 1'b0, F3_LB, 32'h64, 32'h0, 0, 32'h80FF1234,
           32'h64, 32'b0000, 32'h0, 32'h00000034);

    // Error ops
    err_op("sw_mis", 1'b1, F3_SW, 32'h66, 32'd1);
    err_op("ld_f3", 1'b0, 3'b011, 32'h66, 32'd2);
    err_op("st_f3", 1'b1, 3'b100, 32'h64, 32'd2);
    err_op("lh_mis", 1'b0, F3_LH, 32'h65, 32'd1);

    // Word load with bus ready stalled for three cycles
    bus_op("lw_stall", 1'b0, F3_LW, 32'h64, 32'h0, 3, 32'hDEADBEEF,
           32'h64, 32'b0000, 32'h0, 32'hDEADBEEF);

    // Timeout: no response for 4 WAIT cycles
    drive_req(1'b0, F3_LW, 32'h64, 32'h0);
    tick();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    cyc = 0;
    while (bif.resp_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("to.cycles", 32'(cyc), 32'd4);
    chk("to.err", 32'(bif.resp_err), 32'd3);
    chk("to.rdata", bif.resp_rdata, 32'h0);
    tick();
    chk("to.pulse", 32'(bif.resp_valid), 32'd0);
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata     = 32'h11111111;
    tick();
    bif.bus_rsp_valid = 1'b0;
    chk("stray.rv", 32'(bif.resp_valid), 32'd0);
    tick();
    chk("stray.rv2", 32'(bif.resp_valid), 32'd0);
    chk("stray.ready", 32'(bif.req_ready), 32'd1);

    // Async reset in the middle of WAIT
    drive_req(1'b1, F3_SB, 32'h69, 32'h000000A5);
    tick();
    bif.req_valid     = 1'b0;
    bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.ready", 32'(bif.req_ready), 32'd1);
    chk("ar.rv", 32'(bif.resp_valid), 32'd0);
    chk("ar.busv", 32'(bif.bus_req_valid), 32'd0);
    chk("ar.we", 32'(bif.bus_we), 32'd0);
    chk("ar.addr", bif.bus_addr, 32'h0);
    chk("ar.wdata", bif.bus_wdata, 32'h0);
    chk("ar.strb", 32'(bif.bus_wstrb), 32'd0);
    chk("ar.err", 32'(bif.resp_err), 32'd0);
    chk("ar.rdata", bif.resp_rdata, 32'h0);
    tick();
    rst = 1'b0;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata     = 32'h22222222;
    tick();
    bif.bus_rsp_valid = 1'b0;
    chk("late.rv", 32'(bif.resp_valid), 32'd0);
    tick();
    chk("late.rv2", 32'(bif.resp_valid), 32'd0);
    chk("late.ready", 32'(bif.req_ready), 32'd1);
    bus_op("lw_post", 1'b0, F3_LW, 32'h6C, 32'h0, 0, 32'h01234567,
           32'h6C, 32'b0000, 32'h0, 32'h01234567);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_memacc.md
Name: lsu_memacc

Overview:
Load/store unit that implements the MEMACC stage of the multi-cycle RV32I core, downstream of EXECUTE and upstream of WRTBCK. It replaces the core's internal memory array with a word-addressed valid/ready bus. It accepts one memory operation at a time: effective address, funct3 and store data. It performs byte-lane steering, write-strobe generation, load sign/zero extension, misalignment and illegal-funct3 checks, and a bus timeout. It returns a single-cycle completion pulse to the core FSM.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT without bus_rsp_valid before aborting with a timeout error (min 1)
ADDR_W, 32, byte-address width on core and bus side

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core presents a memory op
req_ready  out  1  LSU idle, can accept
req_is_store  in  1  1=store (opcode 0100011), 0=load (0000011)
req_funct3  in  3  RV32I funct3 of the op
req_addr  in  ADDR_W  effective byte address (rs1+imm)
req_wdata  in  32  rs2 value (stores)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores or on error
resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_we  out  1  write enable
bus_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00})
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables; 0000 for reads
bus_rsp_valid  in  1  read data valid / write acknowledged
bus_rdata  in  32  read word

Behaviour:
- Reset (async, any state): FSM=IDLE; req_ready=1. resp_valid, bus_req_valid, bus_we=0; resp_rdata, resp_err, bus_addr, bus_wdata, bus_wstrb, timeout counter=0. An in-flight bus transaction is abandoned; no response is generated after reset releases.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. On req_valid, capture all req_* fields. Then:
  - if funct3 is illegal or the address is misaligned, go to DONE with the error set;
  - otherwise drive the bus fields and go to REQ.
- Illegal funct3: loads 011/110/111; stores >=011.
- Misaligned: half-word ops with addr[0]=1; word ops with addr[1:0]!=00.
- Error priority: illegal funct3 over misaligned.
- REQ: bus_req_valid=1 with stable bus_* until bus_req_ready is sampled 1; then deassert and go to WAIT with the counter cleared.
- WAIT: on bus_rsp_valid, latch the result, then go to DONE. Otherwise increment the counter; when it reaches TIMEOUT_CYCLES, go to DONE with err=11.
- DONE: resp_valid=1 for exactly one cycle with resp_rdata/resp_err stable, then IDLE.
- resp_rdata/resp_err hold their values until the next completion.
- bus_rsp_valid outside WAIT is ignored.
- Latency, zero-wait bus (ready=1 in REQ, rsp in first WAIT cycle): accept at cycle N, bus_req_valid at N+1, rsp at N+2, resp_valid at N+3.
- Latency, error op: resp_valid at N+1; no bus activity.
- Store steering (byte lane b=addr[1:0]):
  - SB: wstrb=1<<b, wdata={4{rs2[7:0]}}.
  - SH: wstrb=0011 or 1100 by addr[1], wdata={2{rs2[15:0]}}.
  - SW: wstrb=1111, wdata=rs2.
- Load extraction:
  - LB/LBU: select byte b, sign-/zero-extend.
  - LH/LHU: select half addr[1], sign-/zero-extend.
  - LW: full word.
- Stores complete on bus_rsp_valid (write ack); resp_rdata=0.
- Back-to-back: req_ready is 0 from REQ through DONE, so a new request is accepted no earlier than the cycle after resp_valid.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW;
  - lsu_state_e enum {IDLE,REQ,WAIT,DONE};
  - lsu_err_e {ERR_NONE,ERR_MISALIGN,ERR_FUNCT3,ERR_TIMEOUT}.
- Sub-module lsu_align: purely combinational. Inputs: funct3, addr[1:0], wdata, rdata. Outputs: wstrb, steered wdata, extended rdata, misalign/illegal flags. Instantiated once in lsu_memacc, which owns FSM and timeout counter.

Test Plan:
- SB, addr=0x66, wdata=0x123456AB, zero-wait bus -> bus_addr=0x64, wstrb=0100, wdata=0xABABABAB, we=1; resp_valid at N+3, err=00, rdata=0.
- LB, addr=0x66, bus_rdata=0x80FF1234 -> resp_rdata=0xFFFFFFFF. Same with LBU -> 0x000000FF. LH -> 0xFFFF80FF. LHU -> 0x000080FF.
- LW, addr=0x64, bus_req_ready held low 3 cycles -> bus_req_valid and bus_addr stable for all 4 cycles; rsp 0xDEADBEEF -> resp_rdata=0xDEADBEEF.
- Error ops:
  - SW at addr=0x66 -> resp_valid at N+1, err=01, no bus_req_valid.
  - Load funct3=011 at addr=0x66 -> err=10 (priority over misalign).
- Timeout: TIMEOUT_CYCLES=4, LW accepted, no bus_rsp_valid -> resp_valid with err=11, rdata=0. A stray bus_rsp_valid injected while in IDLE afterwards produces no resp_valid.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, req_ready=1. After release, a late bus_rsp_valid produces no resp_valid, and a following LW completes normally.
